// File: rtl/sevenseg_pkg.sv
// Shared character codes, FSM state type and helpers for the scrolling 7-segment driver.
package sevenseg_pkg;

   localparam logic [3:0] CHAR_MINUS = 4'hA;
   localparam logic [3:0] CHAR_BLANK = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_e;

   // Decimal digits needed for a magnitude of up to 2^(width-1):
   // ceil((width-1) * log10(2)), with log10(2) approximated as 0.30103.
   // A 1-bit width still needs one digit.
   function automatic int bcd_digits(input int width);
      int acc;
      int d;
      acc = 0;
      for (int i = 0; i < width - 1; i++) begin
         acc += 30103;
      end
      d = (acc + 99999) / 100000;
      if (d < 1) begin
         d = 1;
      end
      return d;
   endfunction

   // Character code to active-low segment pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_decode(input logic [3:0] ch);
      logic [6:0] s;
      case (ch)
         4'd0:       s = 7'b1000000;
         4'd1:       s = 7'b1111001;
         4'd2:       s = 7'b0100100;
         4'd3:       s = 7'b0110000;
         4'd4:       s = 7'b0011001;
         4'd5:       s = 7'b0010010;
         4'd6:       s = 7'b0000010;
         4'd7:       s = 7'b1111000;
         4'd8:       s = 7'b0000000;
         4'd9:       s = 7'b0010000;
         CHAR_MINUS: s = 7'b0111111;
         default:    s = 7'h7F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: W shift cycles, then a one-cycle DONE
// state during which bcd_o is final and done_o pulses.
module bin2bcd_seq
   import sevenseg_pkg::*;
#(
   parameter int W  = 24,
   parameter int ND = 7
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [W-1:0]    mag_i,
   output logic [4*ND-1:0] bcd_o,
   output logic            done_o
);

   localparam int CW = $clog2(W + 1);

   bcd_state_e      state_q, state_d;
   logic [W-1:0]    bin_q, bin_d;
   logic [4*ND-1:0] bcd_q, bcd_d;
   logic [4*ND-1:0] bcd_corr;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Add-3 correction on every nibble that would overflow past 9 when doubled.
   genvar gi;
   generate
      for (gi = 0; gi < ND; gi++) begin : g_corr
         assign bcd_corr[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                      (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
      end
   endgenerate

   // Next-state and datapath: load on accept, shift W times, then commit.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               state_d = SHIFT;
               bin_d   = mag_i;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            bcd_d = {bcd_corr[4*ND-2:0], bin_q[W-1]};
            bin_d = {bin_q[W-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready_o = (state_q == IDLE);
   assign done_o  = (state_q == DONE);
   assign bcd_o   = bcd_q;

endmodule

// File: rtl/sevenseg_scroll_driver.sv
// Signed multiplexed 7-segment driver with leading-zero blanking, optional
// scrolling window and PWM brightness; all timing from enable ticks.
module sevenseg_scroll_driver
   import sevenseg_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 100000000,
   parameter int BIN_WIDTH       = 24,
   parameter int NUM_DIGITS      = 4,
   parameter int REFRESH_HZ      = 1000,
   parameter int SCROLL_HZ       = 2,
   parameter int PWM_WIDTH       = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [BIN_WIDTH-1:0]  bin_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  scroll_en_i,
   input  logic [PWM_WIDTH-1:0]  duty_i,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic [6:0]            seg_o
);

   localparam int ND   = bcd_digits(BIN_WIDTH);
   localparam int NC   = ND + 1;
   localparam int RDIV = CLOCK_FREQUENCY / REFRESH_HZ;
   localparam int SDIV = CLOCK_FREQUENCY / SCROLL_HZ;
   localparam int RW   = $clog2(RDIV + 1);
   localparam int SW   = $clog2(SDIV + 1);
   localparam int OW   = $clog2(NC);
   localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int IW   = OW + 1;

   logic [BIN_WIDTH-1:0]  mag;
   logic                  conv_ready, conv_done;
   logic [4*ND-1:0]       conv_bcd;
   int                    msd;
   logic [NC-1:0][3:0]    chars_commit;

   logic                  sign_q, sign_d;
   logic [NC-1:0][3:0]    char_q, char_d;
   logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
   logic [SW-1:0]         scr_cnt_q, scr_cnt_d;
   logic [DW-1:0]         digit_q, digit_d;
   logic [OW-1:0]         offset_q, offset_d;
   logic [PWM_WIDTH-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;

   logic                  ref_tick, scroll_tick, pwm_on;
   logic [IW-1:0]         sum, idx;

   // Two's-complement magnitude; the most-negative value maps to 2^(W-1) unsigned.
   assign mag = bin_i[BIN_WIDTH-1] ? (~bin_i + {{(BIN_WIDTH-1){1'b0}}, 1'b1}) : bin_i;

   bin2bcd_seq #(
      .W  (BIN_WIDTH),
      .ND (ND)
   ) u_bin2bcd (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (valid_i),
      .ready_o (conv_ready),
      .mag_i   (mag),
      .bcd_o   (conv_bcd),
      .done_o  (conv_done)
   );

   assign ready_o = conv_ready;

   // Locate the most significant nonzero digit (0 when the value is zero).
   always_comb begin
      msd = 0;
      for (int i = 0; i < ND; i++) begin
         if (conv_bcd[4*i +: 4] != 4'd0) begin
            msd = i;
         end
      end
   end

   // Blanked character image: digits up to msd, minus directly above it.
   genvar gi;
   generate
      for (gi = 0; gi < NC; gi++) begin : g_char
         if (gi < ND) begin : g_dig
            assign chars_commit[gi] = (sign_q && (gi == msd + 1)) ? CHAR_MINUS :
                                      (gi <= msd) ? conv_bcd[4*gi +: 4] : CHAR_BLANK;
         end else begin : g_top
            assign chars_commit[gi] = (sign_q && (gi == msd + 1)) ? CHAR_MINUS : CHAR_BLANK;
         end
      end
   endgenerate

   // Ticks, digit/offset/PWM counters, commit and registered pin drive.
   always_comb begin
      ref_tick    = (ref_cnt_q == RW'(RDIV - 1));
      scroll_tick = (scr_cnt_q == SW'(SDIV - 1));
      pwm_on      = (pwm_cnt_q < duty_i);
      sum         = IW'(offset_q) + IW'(digit_q);
      idx         = (sum >= IW'(NC)) ? (sum - IW'(NC)) : sum;

      sign_d    = sign_q;
      char_d    = char_q;
      ref_cnt_d = ref_tick ? '0 : ref_cnt_q + RW'(1);
      scr_cnt_d = scroll_tick ? '0 : scr_cnt_q + SW'(1);
      digit_d   = digit_q;
      offset_d  = offset_q;
      pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);

      if (valid_i && conv_ready) begin
         sign_d = bin_i[BIN_WIDTH-1];
      end
      if (conv_done) begin
         char_d = chars_commit;
      end
      if (ref_tick) begin
         digit_d = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + DW'(1);
      end
      if (!scroll_en_i) begin
         offset_d = '0;
      end else if (scroll_tick) begin
         offset_d = (offset_q == OW'(NC - 1)) ? '0 : offset_q + OW'(1);
      end

      // Blank the anodes on refresh-tick cycles so the old segments never ghost.
      an_d  = (pwm_on && !ref_tick) ? ~(NUM_DIGITS'(1) << digit_q) : '1;
      seg_d = seg_decode(char_q[idx[OW-1:0]]);
   end

   // All display state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sign_q    <= 1'b0;
         char_q    <= {NC{CHAR_BLANK}};
         ref_cnt_q <= '0;
         scr_cnt_q <= '0;
         digit_q   <= '0;
         offset_q  <= '0;
         pwm_cnt_q <= '0;
         an_q      <= '1;
         seg_q     <= 7'h7F;
      end else begin
         sign_q    <= sign_d;
         char_q    <= char_d;
         ref_cnt_q <= ref_cnt_d;
         scr_cnt_q <= scr_cnt_d;
         digit_q   <= digit_d;
         offset_q  <= offset_d;
         pwm_cnt_q <= pwm_cnt_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign an_o  = an_q;
   assign seg_o = seg_q;

endmodule
